tdm_mux_seq: RTL and testbench



---
 rtl/tdm_mux_seq_if.sv | 27 ++
 rtl/tdm_mux_seq.sv | 121 ++++++++++++
 tb/tb_tdm_mux_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tdm_mux_seq_if.sv
// rtl/tdm_mux_seq_if.sv - channel, mask and serial-output bundle for tdm_mux_seq
interface tdm_mux_seq_if;
    logic       en;
    logic       i0;
    logic       i1;
    logic       i2;
    logic       i3;
    logic       i4;
    logic       i5;
    logic       i6;
    logic       i7;
    logic [7:0] mask;
    logic       o;
    logic [2:0] sel;
    logic       o_valid;
    logic       frame_start;

    modport master (
        output en, i0, i1, i2, i3, i4, i5, i6, i7, mask,
        input  o, sel, o_valid, frame_start
    );

    modport slave (
        input  en, i0, i1, i2, i3, i4, i5, i6, i7, mask,
        output o, sel, o_valid, frame_start
    );
endinterface

// File: rtl/tdm_mux_seq.sv
// rtl/tdm_mux_seq.sv - round-robin 8-to-1 TDM sequencer with frame marker
// Optional macro TDM_MUX_MASK_EN: honour the mask port (otherwise all slots enabled).
module tdm_mux_seq #(
    parameter int unsigned DWELL = 4
) (
    input  logic         clk,
    input  logic         reset,
    tdm_mux_seq_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] dwell_q, dwell_d;
    logic       o_q, o_d;
    logic       valid_q, valid_d;
    logic       fs_q, fs_d;

    logic [7:0] eff_mask;
    logic [7:0] chan;
    logic       any_en;
    logic [2:0] first_slot;
    logic [2:0] upper_slot;
    logic       has_upper;
    logic [2:0] next_slot;
    logic       next_wraps;

`ifdef TDM_MUX_MASK_EN
    assign eff_mask = bus.mask;
`else
    logic unused_mask;
    assign unused_mask = ^bus.mask;
    assign eff_mask    = 8'hFF;
`endif

    assign chan   = {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0};
    assign any_en = |eff_mask;

    // Lowest enabled slot overall, and lowest enabled slot strictly above sel_q.
    always_comb begin
        first_slot = 3'd0;
        upper_slot = 3'd0;
        has_upper  = 1'b0;
        for (int n = 7; n >= 0; n--) begin
            if (eff_mask[n]) begin
                first_slot = 3'(n);
                if (n > int'(sel_q)) begin
                    upper_slot = 3'(n);
                    has_upper  = 1'b1;
                end
            end
        end
        next_slot  = has_upper ? upper_slot : first_slot;
        next_wraps = !has_upper;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = dwell_q;
        o_d     = o_q;
        valid_d = 1'b0;
        fs_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en && any_en) begin
                    state_d = RUN;
                    sel_d   = first_slot;
                    dwell_d = 8'd0;
                    fs_d    = 1'b1;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    dwell_d = 8'd0;
                end else begin
                    o_d     = chan[sel_q];
                    valid_d = 1'b1;
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = 8'd0;
                        if (!any_en) begin
                            state_d = IDLE;
                        end else begin
                            sel_d = next_slot;
                            fs_d  = next_wraps;
                        end
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            dwell_q <= 8'd0;
            o_q     <= 1'b0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            o_q     <= o_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.o           = o_q;
    assign bus.sel         = sel_q;
    assign bus.o_valid     = valid_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_tdm_mux_seq.sv
// tb/tb_tdm_mux_seq.sv - scoreboard bench for tdm_mux_seq at DWELL=4 and DWELL=1
module tb_tdm_mux_seq;
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] ch;
    logic [7:0] mask;

    always #5 clk = ~clk;

    tdm_mux_seq_if bus4 ();
    tdm_mux_seq_if bus1 ();

    assign bus4.en = en;   assign bus1.en = en;
    assign bus4.mask = mask; assign bus1.mask = mask;
    assign bus4.i0 = ch[0]; assign bus1.i0 = ch[0];
    assign bus4.i1 = ch[1]; assign bus1.i1 = ch[1];
    assign bus4.i2 = ch[2]; assign bus1.i2 = ch[2];
    assign bus4.i3 = ch[3]; assign bus1.i3 = ch[3];
    assign bus4.i4 = ch[4]; assign bus1.i4 = ch[4];
    assign bus4.i5 = ch[5]; assign bus1.i5 = ch[5];
    assign bus4.i6 = ch[6]; assign bus1.i6 = ch[6];
    assign bus4.i7 = ch[7]; assign bus1.i7 = ch[7];

    tdm_mux_seq #(.DWELL(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    tdm_mux_seq #(.DWELL(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct packed {
        logic       chk;
        logic       o;
        logic [2:0] sel;
        logic       v;
        logic       fs;
    } exp_t;

    exp_t exp_q4[$];
    exp_t exp_q1[$];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: slot schedule derived from the list of enabled slots.
    bit m_seen;
    bit m_run [2];
    int m_sel [2];
    int m_cnt [2];
    bit m_o   [2];
    bit m_v   [2];
    bit m_fs  [2];

    function automatic logic [7:0] eff_of(input logic [7:0] m);
`ifdef TDM_MUX_MASK_EN
        return m;
`else
        return 8'hFF;
`endif
    endfunction

    task automatic model_step(input int k, input int dwell);
        int   slots[$];
        int   nxt;
        logic [7:0] eff;
        exp_t e;
        eff = eff_of(mask);
        for (int n = 0; n < 8; n++) if (eff[n]) slots.push_back(n);
        if (reset) begin
            m_run[k] = 0; m_sel[k] = 0; m_cnt[k] = 0;
            m_o[k] = 0; m_v[k] = 0; m_fs[k] = 0;
        end else if (!m_run[k]) begin
            m_v[k]  = 0;
            m_fs[k] = 0;
            if (en && slots.size() > 0) begin
                m_run[k] = 1; m_sel[k] = slots[0]; m_cnt[k] = 0; m_fs[k] = 1;
            end
        end else if (!en) begin
            m_run[k] = 0; m_cnt[k] = 0; m_v[k] = 0; m_fs[k] = 0;
        end else begin
            m_o[k]  = ch[m_sel[k]];
            m_v[k]  = 1;
            m_fs[k] = 0;
            m_cnt[k]++;
            if (m_cnt[k] == dwell) begin
                m_cnt[k] = 0;
                if (slots.size() == 0) begin
                    m_run[k] = 0;
                end else begin
                    nxt = -1;
                    foreach (slots[j]) if (nxt < 0 && slots[j] > m_sel[k]) nxt = slots[j];
                    if (nxt < 0) begin
                        nxt     = slots[0];
                        m_fs[k] = 1;
                    end
                    m_sel[k] = nxt;
                end
            end
        end
        e.chk = m_seen;
        e.o   = m_o[k];
        e.sel = 3'(m_sel[k]);
        e.v   = m_v[k];
        e.fs  = m_fs[k];
        if (k == 0) exp_q4.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    always @(posedge clk) begin
        if (reset) m_seen = 1;
        model_step(0, 4);
        model_step(1, 1);
        cycle++;
    end

    task automatic compare(input string name, input exp_t e, input exp_t g);
        if (!e.chk) return;
        checks++;
        if (g[4:0] !== e[4:0]) begin
            errors++;
            $display("FAIL %s cycle %0d got o=%b sel=%0d o_valid=%b frame_start=%b exp o=%b sel=%0d o_valid=%b frame_start=%b",
                     name, cycle, g.o, g.sel, g.v, g.fs, e.o, e.sel, e.v, e.fs);
        end
    endtask

    always @(negedge clk) begin
        exp_t g;
        if (exp_q4.size() > 0) begin
            g = {1'b1, bus4.o, bus4.sel, bus4.o_valid, bus4.frame_start};
            compare("dwell4", exp_q4.pop_front(), g);
        end
        if (exp_q1.size() > 0) begin
            g = {1'b1, bus1.o, bus1.sel, bus1.o_valid, bus1.frame_start};
            compare("dwell1", exp_q1.pop_front(), g);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pick [5];
        pick[0] = 8'hFF; pick[1] = 8'h00; pick[2] = 8'h01; pick[3] = 8'hA4; pick[4] = 8'h00;
        m_seen = 0;
        foreach (m_run[k]) begin
            m_run[k] = 0; m_sel[k] = 0; m_cnt[k] = 0; m_o[k] = 0; m_v[k] = 0; m_fs[k] = 0;
        end
        reset = 1'b1; en = 1'b0; ch = 8'h00; mask = 8'hFF;
        cyc(3);
        reset = 1'b0;
        cyc(3);
        ch = 8'b0100_1101;
        en = 1'b1;
        cyc(70);
        en = 1'b0;
        cyc(3);
        en = 1'b1;
        cyc(20);
        mask = 8'h00;
        cyc(10);
        mask = 8'h01;
        cyc(20);
        mask = 8'hA4;
        cyc(40);
        mask = 8'hFF;
        cyc(27);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(30);
        for (int t = 0; t < 120; t++) begin
            if (t % 17 == 0) ch = 8'($urandom);
            cyc(1);
        end
        for (int t = 0; t < 600; t++) begin
            ch = 8'($urandom);
            en = ($urandom % 16) != 0;
            if ($urandom % 25 == 0) begin
                pick[4] = 8'($urandom);
                mask = pick[$urandom % 5];
            end
            reset = ($urandom % 100) == 0;
            cyc(1);
        end
        reset = 1'b0;
        en = 1'b0;
        cyc(2);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
